// File: rtl/bb_driver_if.sv
// bb_driver bus bundle: request/response handshakes plus the black-box drive/sample wires.
interface bb_driver_if;
   logic        io_req_valid;
   logic        io_req_ready;
   logic [31:0] io_req_bits;
   logic        io_resp_valid;
   logic        io_resp_ready;
   logic [31:0] io_resp_bits;
   logic [31:0] io_bb_input;
   logic [31:0] io_bb_output;
   logic        io_busy;

   // Environment side: producer, consumer and black box.
   modport master (
      output io_req_valid, io_req_bits, io_resp_ready, io_bb_output,
      input  io_req_ready, io_resp_valid, io_resp_bits, io_bb_input, io_busy
   );

   // Driver side.
   modport slave (
      input  io_req_valid, io_req_bits, io_resp_ready, io_bb_output,
      output io_req_ready, io_resp_valid, io_resp_bits, io_bb_input, io_busy
   );
endinterface

// File: rtl/bb_driver.sv
// Drives request words into a fixed-latency black box and returns its results in
// order through a credit-protected response FIFO.
module bb_driver #(
   parameter int unsigned LATENCY = 1,
   parameter int unsigned DEPTH   = 4
) (
   input  logic       clock,
   input  logic       reset,
   bb_driver_if.slave bus
);
   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;
   localparam int unsigned VLD_W = LATENCY + 1;
   localparam int unsigned OCC_W = $clog2(DEPTH + LATENCY + 2) + 1;

   logic [VLD_W-1:0] vld_q, vld_d;
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [31:0]      bb_in_q, bb_in_d;
   logic [31:0]      mem_q [DEPTH];
   logic [31:0]      mem_d [DEPTH];

   logic             fire_c, push_c, pop_c;
   logic [OCC_W-1:0] inflight_c, occ_c;

   // Credit: every accepted word is either in flight or buffered until popped.
   always_comb begin
      inflight_c = OCC_W'($countones(vld_q));
      occ_c      = inflight_c + OCC_W'(cnt_q);
   end

   assign bus.io_req_ready  = (occ_c < OCC_W'(DEPTH)) & ~reset;
   assign fire_c            = bus.io_req_valid & bus.io_req_ready;
   assign push_c            = vld_q[LATENCY];
   assign bus.io_resp_valid = (cnt_q != '0);
   assign pop_c             = bus.io_resp_valid & bus.io_resp_ready;
   assign bus.io_resp_bits  = mem_q[rd_ptr_q];
   assign bus.io_bb_input   = bb_in_q;
   assign bus.io_busy       = (occ_c != '0);

   // Next state: in-flight shift, held black-box drive, FIFO pointers/count/storage.
   always_comb begin
      vld_d    = VLD_W'({vld_q, fire_c});
      bb_in_d  = fire_c ? bus.io_req_bits : bb_in_q;
      wr_ptr_d = wr_ptr_q + PTR_W'(push_c);
      rd_ptr_d = rd_ptr_q + PTR_W'(pop_c);
      cnt_d    = cnt_q + CNT_W'(push_c) - CNT_W'(pop_c);
      mem_d    = mem_q;
      if (push_c) begin
         mem_d[wr_ptr_q] = bus.io_bb_output;
      end
   end

   // State registers; reset discards everything in flight or buffered.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         vld_q    <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
         bb_in_q  <= '0;
         for (int unsigned i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else begin
         vld_q    <= vld_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         cnt_q    <= cnt_d;
         bb_in_q  <= bb_in_d;
         mem_q    <= mem_d;
      end
   end

   // Credit accounting must make a push into a full FIFO impossible.
   a_no_overflow : assert property (@(posedge clock) disable iff (reset)
      !(push_c && (cnt_q == CNT_W'(DEPTH))));

endmodule
